instr_encoder: RTL and testbench

Sequential instruction encoder and program loader for the MIPS pipeline: the encoding counterpart of the opcode decoder. It accepts one instruction per valid/ready handshake as a mnemonic code plus register and immediate fields, assembles the 32-bit MIPS word (R, I or J format), and writes it into instruction memory at consecutive word addresses. It sits between the test or boot front end and the instruction memory write port, and only emits opcodes and functs that the pipeline control path supports.

---
 rtl/instr_encoder.sv | 231 +++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Sequential MIPS instruction encoder and program loader. It takes one
// instruction per valid/ready handshake, given as a mnemonic code plus
// register, immediate and jump-target fields. It assembles the 32-bit MIPS
// word in R, I or J format and writes it into instruction memory at
// consecutive word addresses, starting from address 0 on every new load.
//
// Parameters
//   ADDR_WIDTH  instruction memory word-address width (DEPTH = 2**ADDR_WIDTH)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-high; returns everything to IDLE
//   start      begins a new load at address 0 (only honoured in IDLE)
//   in_valid   source presents an instruction
//   in_ready   encoder can accept (high only in LOAD)
//   in_op      mnemonic code (0..13 legal, 14/15 illegal)
//   in_rs/rt/rd  register fields
//   in_imm     16-bit immediate/offset, inserted unmodified
//   in_target  26-bit jump target
//   in_last    marks the final instruction of the program
//   mem_we     instruction memory write strobe
//   mem_addr   write word address
//   mem_wdata  encoded instruction word
//   busy       encoder is not idle
//   done       one-cycle pulse when the load completes
//   err        sticky: an illegal in_op was seen during this load
//   full       sticky: memory filled before in_last arrived
//   count      number of words written in this load
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);

    // FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Mnemonic codes presented on in_op
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_SLTI = 4'd6;
    localparam logic [3:0] OP_ANDI = 4'd7;
    localparam logic [3:0] OP_ORI  = 4'd8;
    localparam logic [3:0] OP_XORI = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_LW   = 4'd11;
    localparam logic [3:0] OP_SW   = 4'd12;
    localparam logic [3:0] OP_J    = 4'd13;

    // MIPS primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Last writable word address; reaching it without in_last means full
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           word;
    logic                  last_q;

    // Combinational encoder results for the instruction currently on the bus
    logic                  is_rtype;
    logic                  is_itype;
    logic                  is_jtype;
    logic [5:0]            enc_opcode;
    logic [5:0]            enc_funct;
    logic                  enc_legal;
    logic [31:0]           enc_word;

    // Classify the mnemonic into a format and pick its opcode / funct.
    // Codes 14 and 15 fall through to the default and are flagged illegal,
    // so only operations the pipeline control path understands get emitted.
    always_comb begin
        is_rtype   = 1'b0;
        is_itype   = 1'b0;
        is_jtype   = 1'b0;
        enc_opcode = OPC_RTYPE;
        enc_funct  = 6'h00;
        case (in_op)
            OP_ADD:  begin is_rtype = 1'b1; enc_funct = FN_ADD; end
            OP_SUB:  begin is_rtype = 1'b1; enc_funct = FN_SUB; end
            OP_AND:  begin is_rtype = 1'b1; enc_funct = FN_AND; end
            OP_OR:   begin is_rtype = 1'b1; enc_funct = FN_OR;  end
            OP_SLT:  begin is_rtype = 1'b1; enc_funct = FN_SLT; end
            OP_ADDI: begin is_itype = 1'b1; enc_opcode = OPC_ADDI; end
            OP_SLTI: begin is_itype = 1'b1; enc_opcode = OPC_SLTI; end
            OP_ANDI: begin is_itype = 1'b1; enc_opcode = OPC_ANDI; end
            OP_ORI:  begin is_itype = 1'b1; enc_opcode = OPC_ORI;  end
            OP_XORI: begin is_itype = 1'b1; enc_opcode = OPC_XORI; end
            OP_BEQ:  begin is_itype = 1'b1; enc_opcode = OPC_BEQ;  end
            OP_LW:   begin is_itype = 1'b1; enc_opcode = OPC_LW;   end
            OP_SW:   begin is_itype = 1'b1; enc_opcode = OPC_SW;   end
            OP_J:    begin is_jtype = 1'b1; enc_opcode = OPC_J;    end
            default: begin end
        endcase
    end

    // Assemble the word from the selected format. Fields that the format
    // does not use are simply not looked at (e.g. in_rd for I-type), and
    // immediates/offsets go in exactly as supplied.
    always_comb begin
        enc_legal = is_rtype | is_itype | is_jtype;
        enc_word  = 32'h0000_0000;
        if (is_rtype) begin
            enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, enc_funct};
        end else if (is_itype) begin
            enc_word = {enc_opcode, in_rs, in_rt, in_imm};
        end else if (is_jtype) begin
            enc_word = {enc_opcode, in_target};
        end
    end

    // Main load sequencer. LOAD accepts one instruction, WRITE spends one
    // cycle driving the memory port, then either returns for the next
    // instruction or finishes. An illegal op is swallowed in LOAD without
    // a write and without advancing the address. The address wraps to zero
    // after the last word, but the load always ends there with full set, so
    // the wrap is never used to overwrite anything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr   <= '0;
            count  <= '0;
            word   <= 32'h0000_0000;
            last_q <= 1'b0;
            err    <= 1'b0;
            full   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        addr   <= '0;
                        count  <= '0;
                        err    <= 1'b0;
                        full   <= 1'b0;
                        last_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (enc_legal) begin
                            word   <= enc_word;
                            last_q <= in_last;
                            state  <= WRITE;
                        end else begin
                            err   <= 1'b1;
                            state <= in_last ? DONE : LOAD;
                        end
                    end
                end
                WRITE: begin
                    addr  <= addr + 1'b1;
                    count <= count + 1'b1;
                    if (last_q) begin
                        state <= DONE;
                    end else if (addr == ADDR_MAX) begin
                        full  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= LOAD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so that an asynchronous reset
    // drops mem_we, busy and the handshake in the same cycle it is applied.
    always_comb begin
        in_ready  = (state == LOAD);
        mem_we    = (state == WRITE);
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_addr  = addr;
        mem_wdata = word;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder. Instance "dut_a" uses the default
// 8-bit address, instance "dut_b" a 2-bit address so the full condition
// can be reached quickly. Both share clock, reset and instruction fields;
// each has its own start, so only the started one consumes instructions.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a;
    logic        start_b;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    logic        a_in_ready, a_mem_we, a_busy, a_done, a_err, a_full;
    logic [7:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [8:0]  a_count;

    logic        b_in_ready, b_mem_we, b_busy, b_done, b_err, b_full;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0]  b_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  log_addr_a[$];
    logic [31:0] log_data_a[$];
    logic [1:0]  log_addr_b[$];
    logic [31:0] log_data_b[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .busy(a_busy), .done(a_done), .err(a_err),
        .full(a_full), .count(a_count)
    );

    instr_encoder #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .busy(b_busy), .done(b_done), .err(b_err),
        .full(b_full), .count(b_count)
    );

    // Record every memory write, sampled mid-cycle while the strobe is high
    always @(negedge clk) begin
        if (a_mem_we) begin
            log_addr_a.push_back(a_mem_addr);
            log_data_a.push_back(a_mem_wdata);
        end
        if (b_mem_we) begin
            log_addr_b.push_back(b_mem_addr);
            log_data_b.push_back(b_mem_wdata);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulseStart(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Wait (bounded) for in_ready, then present one instruction for one edge
    task automatic applyStimulus(input bit sel, input logic [3:0] op,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [15:0] imm,
                                 input logic [25:0] tgt, input logic last);
        int waited = 0;
        @(negedge clk);
        while (!(sel ? b_in_ready : a_in_ready) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            checkOutput("ready_timeout", 64'd0, 64'd1);
        end else begin
            in_op     = op;
            in_rs     = rs;
            in_rt     = rt;
            in_rd     = rd;
            in_imm    = imm;
            in_target = tgt;
            in_last   = last;
            in_valid  = 1'b1;
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            in_last   = 1'b0;
        end
    endtask

    // Leaves the bench at the negedge where done is high
    task automatic waitDone(input bit sel);
        int n = 0;
        @(negedge clk);
        while (!(sel ? b_done : a_done) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic checkLogA(input int idx, input logic [7:0] addr,
                             input logic [31:0] data);
        checkOutput($sformatf("a_wr%0d_addr", idx), log_addr_a[idx], addr);
        checkOutput($sformatf("a_wr%0d_data", idx), log_data_a[idx], data);
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
        in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
        in_imm = 16'd0; in_target = 26'd0; in_last = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        checkOutput("rst_mem_we", a_mem_we, 0);
        checkOutput("rst_mem_addr", a_mem_addr, 0);
        checkOutput("rst_mem_wdata", a_mem_wdata, 0);
        checkOutput("rst_in_ready", a_in_ready, 0);
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_done", a_done, 0);
        checkOutput("rst_err", a_err, 0);
        checkOutput("rst_full", a_full, 0);
        checkOutput("rst_count", a_count, 0);
        reset = 1'b0;

        // ADD rs=1 rt=2 rd=3, then an illegal op with last ends the load
        $display("[TB] ADD write and illegal-last termination");
        pulseStart(0);
        @(negedge clk);
        checkOutput("t1_ready", a_in_ready, 1);
        applyStimulus(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        @(negedge clk);
        checkOutput("t1_we", a_mem_we, 1);
        checkOutput("t1_addr", a_mem_addr, 0);
        checkOutput("t1_wdata", a_mem_wdata, 32'h0022_1820);
        checkOutput("t1_ready_wr", a_in_ready, 0);
        @(negedge clk);
        checkOutput("t1_we_off", a_mem_we, 0);
        checkOutput("t1_ready_again", a_in_ready, 1);
        checkOutput("t1_count", a_count, 1);
        checkOutput("t1_addr_inc", a_mem_addr, 1);
        applyStimulus(0, 4'd14, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
        @(negedge clk);
        checkOutput("t1_done", a_done, 1);
        checkOutput("t1_no_we", a_mem_we, 0);
        checkOutput("t1_err", a_err, 1);
        checkOutput("t1_count_hold", a_count, 1);
        @(negedge clk);
        checkOutput("t1_done_off", a_done, 0);
        checkOutput("t1_idle", a_busy, 0);
        checkOutput("t1_err_sticky", a_err, 1);

        // LW then SW with last
        $display("[TB] LW / SW program");
        log_addr_a.delete(); log_data_a.delete();
        pulseStart(0);
        @(negedge clk);
        checkOutput("t2_err_clr", a_err, 0);
        checkOutput("t2_count_clr", a_count, 0);
        checkOutput("t2_addr_clr", a_mem_addr, 0);
        applyStimulus(0, 4'd11, 5'd9, 5'd8, 5'd0, 16'h0004, 26'd0, 1'b0);
        applyStimulus(0, 4'd12, 5'd0, 5'd5, 5'd0, 16'h0008, 26'd0, 1'b1);
        waitDone(0);
        checkOutput("t2_count", a_count, 2);
        checkOutput("t2_err", a_err, 0);
        @(negedge clk);
        checkOutput("t2_done_off", a_done, 0);
        checkOutput("t2_idle", a_busy, 0);
        checkOutput("t2_nwrites", log_addr_a.size(), 2);
        checkLogA(0, 8'd0, 32'h8D28_0004);
        checkLogA(1, 8'd1, 32'hAC05_0008);

        // J then BEQ with last
        $display("[TB] J / BEQ program");
        log_addr_a.delete(); log_data_a.delete();
        pulseStart(0);
        applyStimulus(0, 4'd13, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0010, 1'b0);
        applyStimulus(0, 4'd10, 5'd1, 5'd2, 5'd7, 16'hFFFF, 26'd0, 1'b1);
        waitDone(0);
        checkOutput("t3_nwrites", log_addr_a.size(), 2);
        checkLogA(0, 8'd0, 32'h0800_0010);
        checkLogA(1, 8'd1, 32'h1022_FFFF);

        // ADDI, illegal op 14, ADDI; a stray start mid-load is ignored
        $display("[TB] illegal op between two ADDIs");
        log_addr_a.delete(); log_data_a.delete();
        pulseStart(0);
        applyStimulus(0, 4'd5, 5'd0, 5'd1, 5'd9, 16'h0005, 26'd0, 1'b0);
        pulseStart(0);
        applyStimulus(0, 4'd14, 5'd3, 5'd3, 5'd3, 16'h1234, 26'd0, 1'b0);
        @(negedge clk);
        checkOutput("t4_no_we", a_mem_we, 0);
        checkOutput("t4_err", a_err, 1);
        checkOutput("t4_ready", a_in_ready, 1);
        checkOutput("t4_addr_hold", a_mem_addr, 1);
        applyStimulus(0, 4'd5, 5'd0, 5'd1, 5'd0, 16'h0005, 26'd0, 1'b1);
        waitDone(0);
        checkOutput("t4_count", a_count, 2);
        checkOutput("t4_err_done", a_err, 1);
        checkOutput("t4_nwrites", log_addr_a.size(), 2);
        checkLogA(0, 8'd0, 32'h2001_0005);
        checkLogA(1, 8'd1, 32'h2001_0005);

        // Small memory: four ORIs fill it, a fifth is never accepted
        $display("[TB] full on 4-word memory");
        pulseStart(1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 4'd8, 5'd2, 5'd3, 5'd0, 16'(i), 26'd0, 1'b0);
        waitDone(1);
        checkOutput("t5_full", b_full, 1);
        checkOutput("t5_count", b_count, 4);
        checkOutput("t5_err", b_err, 0);
        @(negedge clk);
        checkOutput("t5_done_off", b_done, 0);
        checkOutput("t5_idle", b_busy, 0);
        checkOutput("t5_full_sticky", b_full, 1);
        in_op = 4'd8; in_imm = 16'd4; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_fifth_ready%0d", i), b_in_ready, 0);
        end
        in_valid = 1'b0;
        checkOutput("t5_nwrites", log_addr_b.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("b_wr%0d_addr", i), log_addr_b[i], i);
            checkOutput($sformatf("b_wr%0d_data", i), log_data_b[i],
                        32'h3443_0000 + i);
        end

        // Reset while a write is in flight
        $display("[TB] reset during write");
        pulseStart(0);
        applyStimulus(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        applyStimulus(0, 4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b0);
        @(negedge clk);
        checkOutput("t6_we_before", a_mem_we, 1);
        checkOutput("t6_count_before", a_count, 1);
        reset = 1'b1;
        #1;
        checkOutput("t6_we_rst", a_mem_we, 0);
        checkOutput("t6_busy_rst", a_busy, 0);
        checkOutput("t6_count_rst", a_count, 0);
        @(negedge clk);
        reset = 1'b0;
        log_addr_a.delete(); log_data_a.delete();
        pulseStart(0);
        applyStimulus(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
        waitDone(0);
        checkOutput("t6_nwrites", log_addr_a.size(), 1);
        checkLogA(0, 8'd0, 32'h0022_1820);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
